// File: rtl/internal_node_loader_pkg.sv
// -----------------------------------------------------------------------------
// internal_node_loader_pkg
//   Shared definitions for the internal-node loader:
//     - state_e            : loader FSM states (IDLE / LOAD / DONE)
//     - DEF_* constants    : default word/beat widths, node count, buffer depth
//     - NODE_CNT_W         : width of the node_count port
//     - ptr_width()        : pointer width for a buffer of a given depth
// -----------------------------------------------------------------------------
package internal_node_loader_pkg;

   localparam int unsigned DEF_INTERNAL_WIDTH = 22;
   localparam int unsigned DEF_IN_WIDTH       = 11;
   localparam int unsigned DEF_NUM_NODES      = 127;
   localparam int unsigned DEF_FIFO_DEPTH     = 4;

   // node_count is a fixed 7-bit port, so NUM_NODES must not exceed 127
   localparam int unsigned NODE_CNT_W = 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // A depth-1 buffer still needs a 1-bit pointer to stay legal
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/node_word_fifo.sv
// -----------------------------------------------------------------------------
// node_word_fifo
//   Small synchronous word buffer between the beat packer and the tree sender.
//   Combinational read of the head word; power-of-two depth so the read and
//   write pointers wrap naturally. Occupancy is held in a count that spans
//   0..DEPTH so full and empty are unambiguous.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (empties the buffer)
//   clr        in   synchronous clear (same effect as rst, used at load start)
//   push       in   write push_data at this edge (ignored when full)
//   push_data  in   WIDTH  word to write
//   pop        in   drop the head word at this edge (ignored when empty)
//   pop_data   out  WIDTH  current head word
//   full       out  DEPTH words held
//   empty      out  no words held
// -----------------------------------------------------------------------------
module node_word_fifo
   import internal_node_loader_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_INTERNAL_WIDTH,
   parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = ptr_width(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   logic push_ok;
   logic pop_ok;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign pop_data = mem_q[rd_ptr_q];
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;

      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset: contents are only observable once count says so
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/internal_node_loader.sv
// -----------------------------------------------------------------------------
// internal_node_loader
//   Loads NUM_NODES internal-node words into the tree. Each word is assembled
//   from two upstream beats (first beat = low half, second = high half),
//   buffered in node_word_fifo, and sent one word per cycle whenever the top
//   FSM grants fsm_enable. The sender has no backpressure.
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   start          in   single-cycle load request (honoured only in IDLE)
//   in_data        in   IN_WIDTH  upstream beat payload
//   in_valid       in   upstream beat valid
//   in_ready       out  beat accepted when in_valid && in_ready at an edge
//   fsm_enable     in   permission to write the tree this cycle
//   sender_enable  out  registered; sender_data carries a new node word
//   sender_data    out  INTERNAL_WIDTH  registered node word (holds value)
//   busy           out  high while loading
//   done           out  one-cycle completion pulse, with the final word
//   node_count     out  7  words sent in the current / last load
// -----------------------------------------------------------------------------
module internal_node_loader
   import internal_node_loader_pkg::*;
#(
   parameter int unsigned INTERNAL_WIDTH = DEF_INTERNAL_WIDTH,
   parameter int unsigned IN_WIDTH       = DEF_IN_WIDTH,
   parameter int unsigned NUM_NODES      = DEF_NUM_NODES,
   parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [IN_WIDTH-1:0]       in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      fsm_enable,
   output logic                      sender_enable,
   output logic [INTERNAL_WIDTH-1:0] sender_data,
   output logic                      busy,
   output logic                      done,
   output logic [NODE_CNT_W-1:0]     node_count
);

   localparam logic [NODE_CNT_W-1:0] NODES     = NODE_CNT_W'(NUM_NODES);
   localparam logic [NODE_CNT_W-1:0] LAST_NODE = NODE_CNT_W'(NUM_NODES - 1);

   state_e                    state_q, state_d;
   logic                      phase_q, phase_d;          // 1 = low half held
   logic [IN_WIDTH-1:0]       low_half_q, low_half_d;
   logic [NODE_CNT_W-1:0]     rx_count_q, rx_count_d;    // words pushed this load
   logic [NODE_CNT_W-1:0]     node_count_q, node_count_d;
   logic                      sender_enable_q, sender_enable_d;
   logic [INTERNAL_WIDTH-1:0] sender_data_q, sender_data_d;

   logic                      beat_acc;
   logic                      fifo_clr;
   logic                      fifo_push;
   logic                      fifo_pop;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [INTERNAL_WIDTH-1:0] fifo_wr_data;
   logic [INTERNAL_WIDTH-1:0] fifo_rd_data;

   node_word_fifo #(
      .WIDTH (INTERNAL_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr       (fifo_clr),
      .push      (fifo_push),
      .push_data (fifo_wr_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_rd_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Gating on full alone (not full-and-no-pop) keeps push and pop independent
   assign in_ready     = (state_q == ST_LOAD) && !fifo_full && (rx_count_q < NODES);
   assign beat_acc     = in_valid && in_ready;
   assign fifo_push    = beat_acc && phase_q;
   assign fifo_wr_data = INTERNAL_WIDTH'({in_data, low_half_q});
   assign fifo_pop     = (state_q == ST_LOAD) && fsm_enable && !fifo_empty
                         && (node_count_q < NODES);

   always_comb begin
      state_d         = state_q;
      phase_d         = phase_q;
      low_half_d      = low_half_q;
      rx_count_d      = rx_count_q;
      node_count_d    = node_count_q;
      sender_enable_d = 1'b0;
      sender_data_d   = sender_data_q;
      fifo_clr        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d      = ST_LOAD;
               phase_d      = 1'b0;
               rx_count_d   = '0;
               node_count_d = '0;
               fifo_clr     = 1'b1;
            end
         end

         ST_LOAD: begin
            if (beat_acc) begin
               if (!phase_q) begin
                  low_half_d = in_data;
                  phase_d    = 1'b1;
               end else begin
                  phase_d    = 1'b0;
                  rx_count_d = rx_count_q + 1'b1;
               end
            end
            if (fifo_pop) begin
               sender_enable_d = 1'b1;
               sender_data_d   = fifo_rd_data;
               node_count_d    = node_count_q + 1'b1;
               if (node_count_q == LAST_NODE) begin
                  state_d = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         phase_q         <= 1'b0;
         low_half_q      <= '0;
         rx_count_q      <= '0;
         node_count_q    <= '0;
         sender_enable_q <= 1'b0;
         sender_data_q   <= '0;
      end else begin
         state_q         <= state_d;
         phase_q         <= phase_d;
         low_half_q      <= low_half_d;
         rx_count_q      <= rx_count_d;
         node_count_q    <= node_count_d;
         sender_enable_q <= sender_enable_d;
         sender_data_q   <= sender_data_d;
      end
   end

   assign sender_enable = sender_enable_q;
   assign sender_data   = sender_data_q;
   assign node_count    = node_count_q;
   assign busy          = (state_q == ST_LOAD);
   // DONE lasts exactly the cycle after the final pop, so it lines up with
   // the last sender_enable without a separate flop
   assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_internal_node_loader.sv
module tb_internal_node_loader;

   localparam int IW = 11;
   localparam int WW = 22;
   localparam int NN = 127;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [IW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          fsm_enable = 1'b0;
   logic          in_ready;
   logic          sender_enable;
   logic [WW-1:0] sender_data;
   logic          busy;
   logic          done;
   logic [6:0]    node_count;

   internal_node_loader #(
      .INTERNAL_WIDTH (WW),
      .IN_WIDTH       (IW),
      .NUM_NODES      (NN),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .fsm_enable    (fsm_enable),
      .sender_enable (sender_enable),
      .sender_data   (sender_data),
      .busy          (busy),
      .done          (done),
      .node_count    (node_count)
   );

   initial forever #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Reference model: beats pair up as {second, first}; words must leave in
   // the order they were completed, each exactly once.
   bit            tb_phase;
   logic [IW-1:0] tb_low;
   logic [WW-1:0] exp_q[$];
   logic [WW-1:0] obs_q[$];
   logic [IW-1:0] acc_beats[$];
   int            done_cnt;
   bit            done_with_se;
   int            done_at;
   bit            last_acc;
   bit            last_rdy;

   task automatic clear_model();
      tb_phase = 0;
      tb_low   = '0;
      exp_q.delete();
      obs_q.delete();
      acc_beats.delete();
      done_cnt     = 0;
      done_with_se = 0;
      done_at      = 0;
   endtask

   // Drive one cycle: inputs at the falling edge, acceptance judged on the
   // settled pre-edge values, outputs sampled 1 unit after the rising edge.
   task automatic step(input bit r, input bit st, input bit iv,
                       input logic [IW-1:0] d, input bit fe);
      @(negedge clk);
      rst        = r;
      start      = st;
      in_valid   = iv;
      in_data    = d;
      fsm_enable = fe;
      #1;
      last_rdy = in_ready;
      last_acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (r) begin
         tb_phase = 0;
      end else if (last_acc) begin
         acc_beats.push_back(d);
         if (!tb_phase) tb_low = d;
         else           exp_q.push_back({d, tb_low});
         tb_phase = !tb_phase;
      end
      if (sender_enable) obs_q.push_back(sender_data);
      if (done) begin
         done_cnt++;
         done_with_se = sender_enable;
         done_at      = obs_q.size();
      end
   endtask

   function automatic int count_mismatch();
      int m = 0;
      if (obs_q.size() != exp_q.size()) m++;
      for (int i = 0; i < obs_q.size(); i++) begin
         if (i >= exp_q.size()) m++;
         else if (obs_q[i] !== exp_q[i]) m++;
      end
      return m;
   endfunction

   // Offer beats (held until accepted) until done is seen or the budget runs out
   task automatic drive_load(input int vpct, input int fpct, input int spct,
                             input int max_cyc, output bit timed_out);
      logic [IW-1:0] beat;
      int n;
      int d0;
      beat = IW'($urandom);
      n = 0;
      d0 = done_cnt;
      timed_out = 1;
      while (n < max_cyc) begin
         step(0, (spct > 0) && ($urandom_range(99) < spct),
              $urandom_range(99) < vpct, beat, $urandom_range(99) < fpct);
         n++;
         if (last_acc) beat = IW'($urandom);
         if (done_cnt != d0) begin
            timed_out = 0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      step(1, 0, 0, '0, 0);
      step(1, 1, 1, 11'h555, 1);
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
      total_cnt++; if (sender_enable !== 1'b0) $display("FAIL reset_sender_enable: got %b want 0", sender_enable); else pass_cnt++;
      total_cnt++; if (sender_data !== 22'h0) $display("FAIL reset_sender_data: got %h want 0", sender_data); else pass_cnt++;
      total_cnt++; if (node_count !== 7'd0) $display("FAIL reset_node_count: got %0d want 0", node_count); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else pass_cnt++;
      step(0, 0, 0, '0, 0);
      clear_model();
   endtask

   task automatic test_full_load();
      bit to;
      logic [WW-1:0] w0;
      clear_model();
      step(0, 1, 0, '0, 1);
      total_cnt++; if (busy !== 1'b1) $display("FAIL full_busy_after_start: got %b want 1", busy); else pass_cnt++;
      drive_load(100, 100, 0, 400, to);
      total_cnt++; if (to !== 1'b0) $display("FAIL full_timeout: got %b want 0", to); else pass_cnt++;
      total_cnt++; if (obs_q.size() != NN) $display("FAIL full_word_count: got %0d want %0d", obs_q.size(), NN); else pass_cnt++;
      total_cnt++; if (count_mismatch() != 0) $display("FAIL full_word_order: got %0d mismatches want 0", count_mismatch()); else pass_cnt++;
      w0 = {acc_beats[1], acc_beats[0]};
      total_cnt++; if (obs_q[0] !== w0) $display("FAIL full_word0: got %h want %h", obs_q[0], w0); else pass_cnt++;
      total_cnt++; if (acc_beats.size() != 2*NN) $display("FAIL full_beats: got %0d want %0d", acc_beats.size(), 2*NN); else pass_cnt++;
      total_cnt++; if (done_with_se !== 1'b1 || done_at != NN) $display("FAIL full_done_with_last: got se=%b at %0d want se=1 at %0d", done_with_se, done_at, NN); else pass_cnt++;
      total_cnt++; if (node_count !== 7'd127) $display("FAIL full_node_count: got %0d want 127", node_count); else pass_cnt++;
      for (int i = 0; i < 3; i++) step(0, 0, 1, 11'h123, 1);
      total_cnt++; if (done_cnt != 1) $display("FAIL full_done_pulses: got %0d want 1", done_cnt); else pass_cnt++;
      total_cnt++; if (node_count !== 7'd127) $display("FAIL full_count_hold: got %0d want 127", node_count); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL full_idle_after: got busy=%b in_ready=%b want 0 0", busy, in_ready); else pass_cnt++;
      total_cnt++; if (obs_q.size() != NN) $display("FAIL full_no_extra_words: got %0d want %0d", obs_q.size(), NN); else pass_cnt++;
   endtask

   task automatic test_latency();
      clear_model();
      step(0, 1, 0, '0, 1);
      step(0, 0, 1, 11'h001, 1);
      step(0, 0, 1, 11'h7FF, 1);
      total_cnt++; if (last_acc !== 1'b1 || sender_enable !== 1'b0) $display("FAIL latency_early: got acc=%b se=%b want 1 0", last_acc, sender_enable); else pass_cnt++;
      step(0, 0, 0, '0, 1);
      total_cnt++; if (sender_enable !== 1'b1 || sender_data !== 22'h3FF801) $display("FAIL latency_word: got se=%b data=%h want 1 3ff801", sender_enable, sender_data); else pass_cnt++;
      total_cnt++; if (node_count !== 7'd1) $display("FAIL latency_count: got %0d want 1", node_count); else pass_cnt++;
      step(1, 0, 0, '0, 0);
      step(0, 0, 0, '0, 0);
      clear_model();
   endtask

   task automatic test_stall();
      logic [IW-1:0] beat;
      logic [5:0] pattern;
      int acc_n;
      clear_model();
      step(0, 1, 0, '0, 0);
      beat = IW'($urandom);
      acc_n = 0;
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 1, beat, 0);
         if (last_acc) begin
            acc_n++;
            beat = IW'($urandom);
         end
      end
      total_cnt++; if (acc_n != 8) $display("FAIL stall_accepted: got %0d want 8", acc_n); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", in_ready); else pass_cnt++;
      total_cnt++; if (obs_q.size() != 0) $display("FAIL stall_no_send: got %0d words want 0", obs_q.size()); else pass_cnt++;
      pattern = '0;
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, '0, 1);
         pattern = {pattern[4:0], sender_enable};
      end
      total_cnt++; if (pattern !== 6'b111100) $display("FAIL stall_drain_pattern: got %b want 111100", pattern); else pass_cnt++;
      total_cnt++; if (count_mismatch() != 0) $display("FAIL stall_drain_words: got %0d mismatches want 0", count_mismatch()); else pass_cnt++;
      step(1, 0, 0, '0, 0);
      step(0, 0, 0, '0, 0);
      clear_model();
   endtask

   task automatic test_mid_reset();
      bit to;
      logic [IW-1:0] beat;
      clear_model();
      step(0, 1, 0, '0, 1);
      beat = IW'($urandom);
      for (int i = 0; i < 600; i++) begin
         step(0, 0, 1'($urandom_range(1)), beat, 1);
         if (last_acc) beat = IW'($urandom);
         if (node_count == 7'd50) break;
      end
      total_cnt++; if (node_count !== 7'd50) $display("FAIL midrst_reach50: got %0d want 50", node_count); else pass_cnt++;
      step(1, 0, 1, beat, 1);
      total_cnt++; if (busy !== 1'b0 || node_count !== 7'd0 || sender_enable !== 1'b0) $display("FAIL midrst_state: got busy=%b cnt=%0d se=%b want 0 0 0", busy, node_count, sender_enable); else pass_cnt++;
      clear_model();
      for (int i = 0; i < 3; i++) step(0, 0, 1, beat, 1);
      total_cnt++; if (obs_q.size() != 0 || in_ready !== 1'b0) $display("FAIL midrst_quiet: got %0d words rdy=%b want 0 0", obs_q.size(), in_ready); else pass_cnt++;
      clear_model();
      step(0, 1, 0, '0, 1);
      drive_load(70, 80, 0, 3000, to);
      total_cnt++; if (to !== 1'b0) $display("FAIL midrst_reload_timeout: got %b want 0", to); else pass_cnt++;
      total_cnt++; if (obs_q.size() != NN || count_mismatch() != 0) $display("FAIL midrst_reload_words: got %0d words %0d mismatches want %0d 0", obs_q.size(), count_mismatch(), NN); else pass_cnt++;
      total_cnt++; if (node_count !== 7'd127 || done_cnt != 1) $display("FAIL midrst_reload_done: got cnt=%0d done=%0d want 127 1", node_count, done_cnt); else pass_cnt++;
   endtask

   task automatic test_start_ignored();
      bit to;
      clear_model();
      step(0, 1, 0, '0, 1);
      drive_load(80, 90, 15, 3000, to);
      total_cnt++; if (to !== 1'b0) $display("FAIL startign_timeout: got %b want 0", to); else pass_cnt++;
      step(0, 1, 0, '0, 1);
      total_cnt++; if (busy !== 1'b0 || node_count !== 7'd127) $display("FAIL startign_done_start: got busy=%b cnt=%0d want 0 127", busy, node_count); else pass_cnt++;
      step(0, 0, 0, '0, 1);
      total_cnt++; if (busy !== 1'b0) $display("FAIL startign_stays_idle: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (obs_q.size() != NN || count_mismatch() != 0) $display("FAIL startign_words: got %0d words %0d mismatches want %0d 0", obs_q.size(), count_mismatch(), NN); else pass_cnt++;
      total_cnt++; if (done_cnt != 1) $display("FAIL startign_done_pulses: got %0d want 1", done_cnt); else pass_cnt++;
   endtask

   task automatic test_random();
      bit to;
      int fp;
      for (int k = 0; k < 2; k++) begin
         fp = (k == 0) ? 50 : 30;
         clear_model();
         step(0, 1, 0, '0, 0);
         drive_load(50, fp, 0, 4000, to);
         total_cnt++; if (to !== 1'b0) $display("FAIL random_timeout[%0d]: got %b want 0", k, to); else pass_cnt++;
         total_cnt++; if (obs_q.size() != NN) $display("FAIL random_count[%0d]: got %0d want %0d", k, obs_q.size(), NN); else pass_cnt++;
         total_cnt++; if (count_mismatch() != 0) $display("FAIL random_order[%0d]: got %0d mismatches want 0", k, count_mismatch()); else pass_cnt++;
         total_cnt++; if (done_with_se !== 1'b1 || node_count !== 7'd127) $display("FAIL random_done[%0d]: got se=%b cnt=%0d want 1 127", k, done_with_se, node_count); else pass_cnt++;
         step(0, 0, 0, '0, 0);
      end
   endtask

   initial begin
      clear_model();
      test_reset();
      test_full_load();
      test_latency();
      test_stall();
      test_mid_reset();
      test_start_ignored();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1);
   end

endmodule
